// File: rtl/roce_qp_timer_bank.sv
// Per-QP timer bank for the RoCEv2 requester: ACK timeouts and RNR back-offs with
// per-QP retry counting; expiries are serialised onto one valid/ready stream.
module roce_qp_timer_bank #(
    parameter int  NUM_QP          = 4,
    parameter int  CNT_WIDTH       = 32,
    parameter real CLOCK_PERIOD_NS = 3.103,
    parameter int  RETRY_LIMIT     = 7,
    parameter int  RNR_RETRY_LIMIT = 7,
    localparam int QPW             = (NUM_QP > 1) ? $clog2(NUM_QP) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CNT_WIDTH-1:0] ack_timeout_clk,
    input  logic                 s_start_valid,
    input  logic [QPW-1:0]       s_start_qp,
    input  logic                 s_start_mode,
    input  logic [4:0]           s_start_rnr_code,
    input  logic                 s_stop_valid,
    input  logic [QPW-1:0]       s_stop_qp,
    output logic                 m_expire_valid,
    input  logic                 m_expire_ready,
    output logic [QPW-1:0]       m_expire_qp,
    output logic                 m_expire_mode,
    output logic                 m_expire_fatal,
    output logic [2:0]           m_expire_retry_cnt,
    output logic [NUM_QP-1:0]    qp_busy
);

    typedef enum logic [1:0] {CH_IDLE, CH_RUNNING, CH_PENDING} ch_state_t;

    // Encoded RNR timer values in units of 10 us (code 0 is the longest, 655.36 ms)
    function automatic int rnr_units(input int code);
        case (code)
            0:  return 65536;  1:  return 1;     2:  return 2;     3:  return 3;
            4:  return 4;      5:  return 6;     6:  return 8;     7:  return 12;
            8:  return 16;     9:  return 24;    10: return 32;    11: return 48;
            12: return 64;     13: return 96;    14: return 128;   15: return 192;
            16: return 256;    17: return 384;   18: return 512;   19: return 768;
            20: return 1024;   21: return 1536;  22: return 2048;  23: return 3072;
            24: return 4096;   25: return 6144;  26: return 8192;  27: return 12288;
            28: return 16384;  29: return 24576; 30: return 32768; default: return 49152;
        endcase
    endfunction

    function automatic logic [CNT_WIDTH-1:0] rnr_clocks(input int code);
        real ns;
        ns = real'(rnr_units(code)) * 10000.0;
        return CNT_WIDTH'($rtoi(ns / CLOCK_PERIOD_NS));
    endfunction

    logic [CNT_WIDTH-1:0] rnr_table [32];

    genvar g;
    generate
        for (g = 0; g < 32; g++) begin : g_rnr
            localparam logic [CNT_WIDTH-1:0] RNR_CLK = rnr_clocks(g);
            assign rnr_table[g] = RNR_CLK;
        end
    endgenerate

    ch_state_t            state_q     [NUM_QP];
    ch_state_t            state_d     [NUM_QP];
    logic [CNT_WIDTH-1:0] cnt_q       [NUM_QP];
    logic [CNT_WIDTH-1:0] cnt_d       [NUM_QP];
    logic                 mode_q      [NUM_QP];
    logic                 mode_d      [NUM_QP];
    logic [2:0]           ack_retry_q [NUM_QP];
    logic [2:0]           ack_retry_d [NUM_QP];
    logic [2:0]           rnr_retry_q [NUM_QP];
    logic [2:0]           rnr_retry_d [NUM_QP];
    logic                 ev_fatal_q  [NUM_QP];
    logic                 ev_fatal_d  [NUM_QP];
    logic [2:0]           ev_cnt_q    [NUM_QP];
    logic [2:0]           ev_cnt_d    [NUM_QP];

    logic [NUM_QP-1:0]    start_hit;
    logic [NUM_QP-1:0]    stop_hit;
    logic [NUM_QP-1:0]    pend_elig;
    logic [QPW-1:0]       rr_q;
    logic [QPW-1:0]       grant_qp;
    logic                 grant_valid;
    logic                 out_load;
    logic [CNT_WIDTH-1:0] start_load;

    assign out_load   = !m_expire_valid || m_expire_ready;
    assign start_load = s_start_mode ? rnr_table[s_start_rnr_code] : ack_timeout_clk;

    // A channel hit by start or stop this cycle is not offered to the arbiter,
    // so a restarted or stopped QP cannot emit its stale expiry.
    always_comb begin
        for (int i = 0; i < NUM_QP; i++) begin
            start_hit[i] = s_start_valid && (int'(s_start_qp) == i);
            stop_hit[i]  = s_stop_valid && (int'(s_stop_qp) == i);
            pend_elig[i] = (state_q[i] == CH_PENDING) && !start_hit[i] && !stop_hit[i];
            qp_busy[i]   = (state_q[i] != CH_IDLE);
        end
    end

    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_qp    = '0;
        for (int k = 0; k < NUM_QP; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_QP) idx = idx - NUM_QP;
            if (!grant_valid && pend_elig[idx]) begin
                grant_valid = 1'b1;
                grant_qp    = QPW'(idx);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_QP; i++) begin
            state_d[i]     = state_q[i];
            cnt_d[i]       = cnt_q[i];
            mode_d[i]      = mode_q[i];
            ack_retry_d[i] = ack_retry_q[i];
            rnr_retry_d[i] = rnr_retry_q[i];
            ev_fatal_d[i]  = ev_fatal_q[i];
            ev_cnt_d[i]    = ev_cnt_q[i];
            if (stop_hit[i]) begin
                state_d[i]     = CH_IDLE;
                ack_retry_d[i] = '0;
                rnr_retry_d[i] = '0;
            end
            if (start_hit[i]) begin
                state_d[i] = (!s_start_mode && ack_timeout_clk == '0) ? CH_IDLE : CH_RUNNING;
                cnt_d[i]   = start_load;
                mode_d[i]  = s_start_mode;
            end else if (!stop_hit[i]) begin
                if (state_q[i] == CH_PENDING && out_load && grant_valid && int'(grant_qp) == i) begin
                    state_d[i] = CH_IDLE;
                end else if (state_q[i] == CH_RUNNING) begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                    if (cnt_q[i] <= CNT_WIDTH'(1)) begin
                        state_d[i] = CH_PENDING;
                        if (!mode_q[i]) begin
                            ev_fatal_d[i]  = (ack_retry_q[i] == 3'(RETRY_LIMIT));
                            ack_retry_d[i] = ev_fatal_d[i] ? 3'd0 : ack_retry_q[i] + 3'd1;
                            ev_cnt_d[i]    = ack_retry_d[i];
                        end else begin
                            // Limit 7 means unlimited RNR retries: count saturates, never fatal
                            ev_fatal_d[i]  = (RNR_RETRY_LIMIT != 7) && (rnr_retry_q[i] == 3'(RNR_RETRY_LIMIT));
                            rnr_retry_d[i] = ev_fatal_d[i] ? 3'd0 :
                                             (rnr_retry_q[i] == 3'd7) ? 3'd7 : rnr_retry_q[i] + 3'd1;
                            ev_cnt_d[i]    = rnr_retry_d[i];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_QP; i++) begin
                state_q[i]     <= CH_IDLE;
                cnt_q[i]       <= '0;
                mode_q[i]      <= 1'b0;
                ack_retry_q[i] <= '0;
                rnr_retry_q[i] <= '0;
                ev_fatal_q[i]  <= 1'b0;
                ev_cnt_q[i]    <= '0;
            end
            rr_q               <= '0;
            m_expire_valid     <= 1'b0;
            m_expire_qp        <= '0;
            m_expire_mode      <= 1'b0;
            m_expire_fatal     <= 1'b0;
            m_expire_retry_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_QP; i++) begin
                state_q[i]     <= state_d[i];
                cnt_q[i]       <= cnt_d[i];
                mode_q[i]      <= mode_d[i];
                ack_retry_q[i] <= ack_retry_d[i];
                rnr_retry_q[i] <= rnr_retry_d[i];
                ev_fatal_q[i]  <= ev_fatal_d[i];
                ev_cnt_q[i]    <= ev_cnt_d[i];
            end
            if (out_load) begin
                m_expire_valid <= grant_valid;
                if (grant_valid) begin
                    m_expire_qp        <= grant_qp;
                    m_expire_mode      <= mode_q[grant_qp];
                    m_expire_fatal     <= ev_fatal_q[grant_qp];
                    m_expire_retry_cnt <= ev_cnt_q[grant_qp];
                    rr_q               <= (int'(grant_qp) == NUM_QP - 1) ? '0 : grant_qp + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_roce_qp_timer_bank.sv
// Directed bench for roce_qp_timer_bank: expected expiry events are queued at
// start time and compared by a monitor as each event is handshaken.
module tb_roce_qp_timer_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ack_timeout_clk;
    logic        s_start_valid;
    logic [1:0]  s_start_qp;
    logic        s_start_mode;
    logic [4:0]  s_start_rnr_code;
    logic        s_stop_valid;
    logic [1:0]  s_stop_qp;
    logic        m_expire_valid;
    logic        m_expire_ready;
    logic [1:0]  m_expire_qp;
    logic        m_expire_mode;
    logic        m_expire_fatal;
    logic [2:0]  m_expire_retry_cnt;
    logic [3:0]  qp_busy;

    int          vectors     = 0;
    int          miscompares = 0;
    int          lat;
    logic [6:0]  sb [$];
    logic [6:0]  exp_ev;
    logic [2:0]  t3_cnt   [4] = '{3'd1, 3'd2, 3'd0, 3'd1};
    logic        t3_fatal [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  t4_cnt   [4] = '{3'd2, 3'd1, 3'd2, 3'd1};

    always #5 clk = ~clk;

    roce_qp_timer_bank #(
        .NUM_QP(4), .CNT_WIDTH(32), .CLOCK_PERIOD_NS(10.0), .RETRY_LIMIT(2), .RNR_RETRY_LIMIT(7)
    ) dut (
        .clk(clk), .rst(rst), .ack_timeout_clk(ack_timeout_clk),
        .s_start_valid(s_start_valid), .s_start_qp(s_start_qp), .s_start_mode(s_start_mode),
        .s_start_rnr_code(s_start_rnr_code), .s_stop_valid(s_stop_valid), .s_stop_qp(s_stop_qp),
        .m_expire_valid(m_expire_valid), .m_expire_ready(m_expire_ready), .m_expire_qp(m_expire_qp),
        .m_expire_mode(m_expire_mode), .m_expire_fatal(m_expire_fatal),
        .m_expire_retry_cnt(m_expire_retry_cnt), .qp_busy(qp_busy)
    );

    function automatic logic [6:0] ev(input logic [1:0] qp, input logic mode, input logic fatal, input logic [2:0] rc);
        return {qp, mode, fatal, rc};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic sv, input logic [1:0] sqp, input logic smode,
                                 input logic [4:0] code, input logic pv, input logic [1:0] pqp);
        s_start_valid    = sv;
        s_start_qp       = sqp;
        s_start_mode     = smode;
        s_start_rnr_code = code;
        s_stop_valid     = pv;
        s_stop_qp        = pqp;
        @(posedge clk);
        #1;
        s_start_valid = 1'b0;
        s_stop_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitValid(input int limit, output int cycles);
        cycles = 0;
        while (cycles < limit) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (m_expire_valid) break;
        end
    endtask

    // Scoreboard: every handshaken event must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst === 1'b0 && m_expire_valid === 1'b1 && m_expire_ready === 1'b1) begin
            checkOutput("sb_has_entry", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                exp_ev = sb.pop_front();
                checkOutput("event", {m_expire_qp, m_expire_mode, m_expire_fatal, m_expire_retry_cnt}, exp_ev);
            end
        end
    end

    initial begin
        rst = 1'b1; ack_timeout_clk = 32'd100; m_expire_ready = 1'b1;
        s_start_valid = 0; s_start_qp = 0; s_start_mode = 0; s_start_rnr_code = 0;
        s_stop_valid = 0; s_stop_qp = 0;
        idle(3);
        @(negedge clk);
        checkOutput("reset_valid", m_expire_valid, 0);
        checkOutput("reset_busy", qp_busy, 0);
        checkOutput("reset_fields", {m_expire_qp, m_expire_mode, m_expire_fatal, m_expire_retry_cnt}, 0);
        @(posedge clk); #1 rst = 1'b0;
        idle(2);

        $display("[TB] ACK timeout 100 on QP2");
        sb.push_back(ev(2, 0, 0, 1));
        applyStimulus(1, 2, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t1_busy_running", qp_busy, 4'b0100);
        waitValid(300, lat);
        checkOutput("t1_latency", lat, 101);
        checkOutput("t1_busy_granted", qp_busy, 0);
        idle(1);

        $display("[TB] RNR codes 1, 0 and 2 on QP1");
        sb.push_back(ev(1, 1, 0, 1));
        applyStimulus(1, 1, 1, 5'd1, 0, 0);
        waitValid(1500, lat);
        checkOutput("t2_code1_latency", lat, 1001);
        idle(1);
        applyStimulus(1, 1, 1, 5'd0, 0, 0);
        idle(3000);
        @(negedge clk);
        checkOutput("t2_code0_quiet", m_expire_valid, 0);
        checkOutput("t2_code0_busy", qp_busy, 4'b0010);
        applyStimulus(0, 0, 0, 0, 1, 1);
        @(negedge clk);
        checkOutput("t2_stop_busy", qp_busy, 0);
        sb.push_back(ev(1, 1, 0, 1));
        applyStimulus(1, 1, 1, 5'd2, 0, 0);
        waitValid(2500, lat);
        checkOutput("t2_code2_latency", lat, 2001);
        idle(1);

        $display("[TB] retry limit sequence on QP0");
        ack_timeout_clk = 32'd20;
        for (int r = 0; r < 4; r++) begin
            sb.push_back(ev(0, 0, t3_fatal[r], t3_cnt[r]));
            applyStimulus(1, 0, 0, 0, 0, 0);
            waitValid(100, lat);
            checkOutput("t3_latency", lat, 21);
            idle(1);
        end
        sb.push_back(ev(0, 0, 0, 1));
        applyStimulus(1, 0, 0, 0, 1, 0);
        waitValid(100, lat);
        checkOutput("t3_stopstart_latency", lat, 21);
        idle(1);

        $display("[TB] four expiries with ready held low");
        ack_timeout_clk = 32'd50;
        m_expire_ready = 1'b0;
        for (int q = 0; q < 4; q++) begin
            sb.push_back(ev(2'(q), 0, 0, t4_cnt[q]));
            applyStimulus(1, 2'(q), 0, 0, 0, 0);
        end
        idle(55);
        @(negedge clk);
        checkOutput("t4_held_head", {m_expire_valid, m_expire_qp, m_expire_retry_cnt}, {1'b1, 2'd0, 3'd2});
        checkOutput("t4_busy_pending", qp_busy, 4'b1110);
        idle(5);
        @(negedge clk);
        checkOutput("t4_held_stable", {m_expire_valid, m_expire_qp, m_expire_retry_cnt}, {1'b1, 2'd0, 3'd2});
        @(posedge clk); #1 m_expire_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("t4_order", {m_expire_valid, m_expire_qp}, {1'b1, 2'(k)});
        end
        @(negedge clk);
        checkOutput("t4_drained", m_expire_valid, 0);

        $display("[TB] stop at count 1 and disabled ACK timer");
        ack_timeout_clk = 32'd10;
        idle(1);
        applyStimulus(1, 3, 0, 0, 0, 0);
        idle(9);
        applyStimulus(0, 0, 0, 0, 1, 3);
        idle(20);
        @(negedge clk);
        checkOutput("t5_stop_quiet", {m_expire_valid, qp_busy}, 0);
        ack_timeout_clk = 32'd0;
        applyStimulus(1, 1, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t5_disabled_busy", qp_busy, 0);
        idle(20);
        @(negedge clk);
        checkOutput("t5_disabled_quiet", m_expire_valid, 0);

        $display("[TB] restart of a pending QP3 behind a busy output");
        ack_timeout_clk = 32'd10;
        idle(1);
        m_expire_ready = 1'b0;
        sb.push_back(ev(2, 0, 1, 0));
        sb.push_back(ev(3, 0, 0, 2));
        applyStimulus(1, 2, 0, 0, 0, 0);
        applyStimulus(1, 3, 0, 0, 0, 0);
        idle(11);
        @(negedge clk);
        checkOutput("t5b_out_busy", {m_expire_valid, m_expire_qp, m_expire_fatal}, {1'b1, 2'd2, 1'b1});
        checkOutput("t5b_busy", qp_busy, 4'b1000);
        applyStimulus(1, 3, 0, 0, 0, 0);
        idle(2);
        m_expire_ready = 1'b1;
        waitValid(50, lat);
        checkOutput("t5b_restart_latency", lat, 9);
        idle(1);

        $display("[TB] async reset with an event held");
        m_expire_ready = 1'b0;
        ack_timeout_clk = 32'd5;
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        waitValid(20, lat);
        checkOutput("t6_latency", lat, 5);
        checkOutput("t6_pre_reset", {m_expire_valid, m_expire_qp, qp_busy}, {1'b1, 2'd1, 4'b0001});
        #2 rst = 1'b1;
        #1;
        checkOutput("t6_reset_valid", m_expire_valid, 0);
        checkOutput("t6_reset_busy", qp_busy, 0);
        checkOutput("t6_reset_fields", {m_expire_qp, m_expire_retry_cnt}, 0);
        idle(2);
        rst = 1'b0;
        idle(1);
        m_expire_ready = 1'b1;
        idle(10);
        @(negedge clk);
        checkOutput("t6_dropped", m_expire_valid, 0);
        sb.push_back(ev(0, 0, 0, 1));
        applyStimulus(1, 0, 0, 0, 0, 0);
        waitValid(20, lat);
        checkOutput("t6_post_reset_latency", lat, 6);
        idle(2);

        checkOutput("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
